// File: rtl/div_iter_if.sv
// EX-stage divide handshake between the requester (master) and the iterative divider (slave).
interface div_iter_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider serving DIV/DIVU; result_o = {remainder, quotient}.
// Define DIV_ANNUL_EN to let annul_i abort an in-flight divide.
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        resetn,
    div_iter_if.slave   bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   dividend;   // shifts out dividend bits, shifts in quotient bits
    logic [DATA_W-1:0]   divisor;
    logic [DATA_W-1:0]   rem;
    logic                neg_q, neg_r;
    logic [2*DATA_W-1:0] result;
    logic                ready;

    logic                annul, accept, last_iter;
    logic [DATA_W-1:0]   mag1, mag2;
    logic [DATA_W:0]     rem_sh, diff;
    logic [DATA_W-1:0]   rem_nx, quo_nx, rem_fix, quo_fix;

`ifdef DIV_ANNUL_EN
    assign annul = bus.annul_i;
`else
    logic unused_annul;
    assign unused_annul = bus.annul_i;
    assign annul        = 1'b0;
`endif

    assign accept    = bus.start_i & ~annul;
    assign last_iter = (cnt == CNT_W'(DATA_W - 1));

    // Signed mode works on magnitudes; the most negative value maps to 2^(DATA_W-1) unsigned.
    assign mag1 = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign mag2 = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;

    // One restoring step: shift {rem, dividend} left, trial-subtract, keep on no borrow.
    assign rem_sh  = {rem, dividend[DATA_W-1]};
    assign diff    = rem_sh - {1'b0, divisor};
    assign rem_nx  = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
    assign quo_nx  = {dividend[DATA_W-2:0], ~diff[DATA_W]};
    assign quo_fix = neg_q ? -quo_nx : quo_nx;
    assign rem_fix = neg_r ? -rem_nx : rem_nx;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nx;
    end

    // NOTE: state_nx gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept) state_nx = (bus.opdata2_i == '0) ? S_BYZERO : S_ON;
            S_BYZERO: state_nx = annul ? S_IDLE : S_END;
            S_ON: begin
                if (annul)          state_nx = S_IDLE;
                else if (last_iter) state_nx = S_END;
            end
            S_END:    if (annul || !bus.start_i) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // NOTE: every datapath register is cleared by reset, so a mid-divide reset leaves no stale operands.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result   <= '0;
            ready    <= 1'b0;
        end else begin
            ready <= (state_nx == S_END);
            case (state)
                S_IDLE: if (accept) begin
                    neg_q    <= bus.signed_div_i & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                    neg_r    <= bus.signed_div_i & bus.opdata1_i[DATA_W-1];
                    dividend <= mag1;
                    divisor  <= mag2;
                    rem      <= '0;
                    cnt      <= '0;
                end
                S_BYZERO: if (state_nx == S_END) result <= '0;
                S_ON: begin
                    rem      <= rem_nx;
                    dividend <= quo_nx;
                    cnt      <= cnt + CNT_W'(1);
                    if (state_nx == S_END) result <= {rem_fix, quo_fix};
                end
                default: ;
            endcase
        end
    end

    assign bus.result_o = result;
    assign bus.ready_o  = ready;
endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases plus random operands against an arithmetic model.
module tb_div_iter;
    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_fail;
    logic [63:0] last_exp;

    div_iter_if #(.DATA_W(32)) bus ();

    div_iter #(.DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Truncating division in plain 64-bit arithmetic; remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) return 64'd0;
        na = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        nb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        q  = na / nb;
        r  = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // annul_at: -1 never, 0 held for the whole request, k>0 one-cycle pulse after edge k.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int annul_at, input bit drop_start);
        int edges;
        int lat;
        bit got;
        lat = (b == 32'd0) ? 2 : 33;
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        bus.annul_i      = (annul_at == 0);
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~sgn;
            end
            if (annul_at > 0) bus.annul_i = (edges == annul_at);
            if (drop_start && edges == 5) bus.start_i = 1'b0;
            got = bus.ready_o;
        end
        bus.annul_i = 1'b0;
        check({tag, "_latency"}, 64'(edges), 64'(lat));
        check({tag, "_result"}, bus.result_o, exp);
        if (!drop_start || b == 32'd0) begin
            repeat (2) @(negedge clk);
            check({tag, "_end_hold_ready"}, 64'(bus.ready_o), 64'd1);
            check({tag, "_end_hold_result"}, bus.result_o, exp);
        end
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_idle_ready"}, 64'(bus.ready_o), 64'd0);
        check({tag, "_idle_result"}, bus.result_o, exp);
        last_exp = exp;
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a, b;
        bit          saw_ready;
        n_cmp    = 0;
        n_fail   = 0;
        last_exp = 64'd0;
        resetn           = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        #12;
        check("reset_ready", 64'(bus.ready_o), 64'd0);
        check("reset_result", bus.result_o, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        do_div("u_100_7",     1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, -1, 1'b0);
        do_div("s_m7_2",      1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, -1, 1'b0);
        do_div("u_m7_2",      1'b0, 32'hFFFFFFF9,   32'h00000002,   64'h00000001_7FFFFFFC, -1, 1'b0);
        do_div("s_min_m1",    1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, -1, 1'b0);
        do_div("u_max_1",     1'b0, 32'hFFFFFFFF,   32'h00000001,   64'h00000000_FFFFFFFF, -1, 1'b0);
        do_div("byzero",      1'b0, 32'h00001234,   32'd0,          64'd0,                 -1, 1'b0);
        do_div("s_drop",      1'b1, 32'd1000,       32'hFFFFFFFD,   64'h00000001_FFFFFEB3, -1, 1'b1);

`ifdef DIV_ANNUL_EN
        // start with annul in IDLE must not be accepted
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd55;
        bus.opdata2_i    = 32'd5;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b1;
        repeat (40) @(negedge clk);
        check("annul_idle_ready", 64'(bus.ready_o), 64'd0);
        check("annul_idle_result", bus.result_o, last_exp);
        bus.annul_i = 1'b0;
        // accept, run 10 iterations, then abort
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b0;
        saw_ready = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o) saw_ready = 1'b1;
        end
        check("annul_on_no_ready", 64'(saw_ready), 64'd0);
        check("annul_on_result", bus.result_o, last_exp);
        // abort from BYZERO
        bus.opdata2_i = 32'd0;
        bus.start_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b0;
        repeat (3) @(negedge clk);
        check("annul_byzero_ready", 64'(bus.ready_o), 64'd0);
        check("annul_byzero_result", bus.result_o, last_exp);
        do_div("after_annul", 1'b0, 32'd20, 32'd3, 64'h00000002_00000006, -1, 1'b0);
`else
        do_div("annul_pulse_ignored", 1'b0, 32'd55, 32'd5, 64'h00000000_0000000B, 10, 1'b0);
        do_div("annul_held_ignored",  1'b0, 32'd20, 32'd3, 64'h00000002_00000006, 0,  1'b0);
`endif

        // asynchronous reset partway through a divide
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd55;
        bus.opdata2_i    = 32'd5;
        bus.start_i      = 1'b1;
        repeat (17) @(posedge clk);
        #2;
        resetn      = 1'b0;
        bus.start_i = 1'b0;
        #1;
        check("async_reset_ready", 64'(bus.ready_o), 64'd0);
        check("async_reset_result", bus.result_o, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        do_div("post_reset_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, -1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            case ($urandom % 4)
                0:       b = 32'd0;
                1:       b = $urandom % 16;
                2:       b = $urandom;
                default: b = 32'hFFFFFFFF - ($urandom % 8);
            endcase
            if (i % 5 == 0) a = 32'h80000000;
            do_div($sformatf("rand%0d", i), sgn, a, b, ref_div(sgn, a, b), -1, (i % 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle radix-2 restoring divider. It is the responder side of the EX-stage divide handshake: it services DIV/DIVU.
- EX asserts start_i with operands and holds the pipeline until ready_o rises; result_o then feeds HI/LO.
- Result packing: {remainder, quotient}, i.e. HI = result_o[63:32], LO = result_o[31:0].

Parameters:
- DATA_W, 32, operand width; result_o is 2*DATA_W. Iteration counter is clog2(DATA_W)+1 bits.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- resetn  in  1  Reset, asynchronous, active-low.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU). Sampled at accept.
- opdata1_i  in  DATA_W  Dividend (rs). Sampled at accept.
- opdata2_i  in  DATA_W  Divisor (rt). Sampled at accept.
- start_i  in  1  Request. EX holds it high until it sees ready_o.
- annul_i  in  1  Abort of an in-flight divide (see Optional Feature).
- result_o  out  2*DATA_W  {remainder, quotient}.
- ready_o  out  1  Result valid.

Behaviour:
- Reset (resetn=0, asynchronous, any state, including mid-divide):
  - state=IDLE, cnt=0, ready_o=0, result_o=0.
  - Internal dividend, divisor and partial remainder cleared.
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - ready_o=0.
  - If start_i=1 and annul_i=0 (the accept edge), latch signed_div_i and both operands.
  - Divisor==0 -> BYZERO.
  - Otherwise latch magnitudes: in signed mode, negative operands are two's-complement negated. 0x80000000 gives magnitude 2^31 as an unsigned value.
  - Then cnt=0 -> ON.
- BYZERO: next edge sets result_o=0, ready_o=1 -> END.
- ON:
  - One iteration per edge: shift {rem, dividend} left 1 bit, then trial-subtract the divisor from rem.
  - If the difference is non-negative, rem=difference and the quotient bit is 1; otherwise the quotient bit is 0.
  - cnt increments each edge.
  - On the edge where cnt==DATA_W-1, compute the sign fix and register the result:
    - Quotient is negated if signed and dividend_sign XOR divisor_sign.
    - Remainder is negated if signed and dividend_sign.
    - Write result_o, set ready_o=1 -> END.
  - Operand input changes during ON are ignored.
  - start_i dropping during ON does not abort the divide.
- END:
  - ready_o=1 and result_o stable.
  - If start_i=0: next edge ready_o=0 -> IDLE.
  - If start_i stays 1: remain in END. No re-accept without first passing through IDLE.
- Latency, counting the accept edge as edge 1:
  - Non-zero divisor: ready_o high after edge DATA_W+1 (33 for DATA_W=32).
  - Zero divisor: ready_o high after edge 2.
- Boundary cases:
  - result_o holds its last value in IDLE until the next result write.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
  - Unsigned division never negates.
  - start_i together with annul_i in IDLE: not accepted.

Optional Feature:
- Macro DIV_ANNUL_EN.
- Defined:
  - annul_i=1 in ON or BYZERO -> IDLE on the next edge. ready_o stays 0 and result_o is unchanged.
  - annul_i in END -> IDLE, ready_o=0.
- Undefined:
  - annul_i is ignored everywhere, including the IDLE accept condition.
  - Every accepted divide completes.

Test Plan:
- Unsigned 100/7 (signed_div_i=0, start held): ready_o rises after edge 33 with result_o=0x00000002_0000000E. Drop start_i -> ready_o=0 next edge, state IDLE.
- Signed 0xFFFFFFF9 / 0x00000002 (-7/2): result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quot -3). Unsigned, the same operands: result_o=0x00000001_7FFFFFFC.
- Signed 0x80000000 / 0xFFFFFFFF gives 0x00000000_80000000. Unsigned 0xFFFFFFFF / 0x00000001 gives 0x00000000_FFFFFFFF.
- Divisor 0 with dividend 0x1234: ready_o high after edge 2 with result_o=0. Changing opdata1_i after accept has no effect.
- DIV_ANNUL_EN: pulse annul_i at iteration 10 of 55/5 -> IDLE, no ready_o. A new start 20/3 then returns 0x00000002_00000006 after 33 edges.
- Deassert resetn asynchronously at iteration 16 (no clock edge): ready_o=0 and result_o=0 immediately. After release, start 9/3 gives 0x00000000_00000003.
